stoch_signed_decode: RTL and testbench

- Downstream consumer of signed-channel stochastic bitstreams, such as the n-input signed max tree output (y_p / y_m).
- Integrates the signed stream over a fixed window of 2^WINDOW_LOG2 enabled cycles and emits a signed fixed-point estimate.
- The result is delivered over a valid/ready handshake to binary-domain logic (debug readout, loss or compare stages).

---
 rtl/stoch_signed_decode.sv | 105 ++++++++++
 tb/tb_stoch_signed_decode.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stoch_signed_decode.sv
// Integrates a signed (x_p/x_m) stochastic bitstream over 2^WINDOW_LOG2 enabled
// samples and hands each window sum to binary logic over a valid/ready handshake.
module stoch_signed_decode #(
    parameter int WINDOW_LOG2 = 8,
    parameter int OUT_WIDTH   = WINDOW_LOG2 + 2
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        clr,
    input  logic                        en,
    input  logic                        x_p,
    input  logic                        x_m,
    output logic signed [OUT_WIDTH-1:0] y,
    output logic                        y_valid,
    input  logic                        y_ready,
    output logic                        overrun
);

    generate
        if (WINDOW_LOG2 < 1 || WINDOW_LOG2 > 16) begin : g_bad_window
            $error("stoch_signed_decode: WINDOW_LOG2 must be in 1..16");
        end
        if (OUT_WIDTH != WINDOW_LOG2 + 2) begin : g_bad_width
            $error("stoch_signed_decode: OUT_WIDTH must equal WINDOW_LOG2+2");
        end
    endgenerate

    localparam logic signed [OUT_WIDTH-1:0] ACC_ZERO  = '0;
    localparam logic signed [OUT_WIDTH-1:0] ACC_PLUS  = OUT_WIDTH'(1);
    localparam logic signed [OUT_WIDTH-1:0] ACC_MINUS = '1;
    localparam logic [WINDOW_LOG2-1:0]      CNT_ONE   = WINDOW_LOG2'(1);
    localparam logic [WINDOW_LOG2-1:0]      CNT_LAST  = '1;

    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [WINDOW_LOG2-1:0]      cnt_q, cnt_d;
    logic signed [OUT_WIDTH-1:0] y_q, y_d;
    logic                        y_valid_q, y_valid_d;
    logic                        overrun_q, overrun_d;

    logic signed [OUT_WIDTH-1:0] d_inc;
    logic signed [OUT_WIDTH-1:0] acc_sum;
    logic                        complete;
    logic                        transfer;

    // Both channels high cancel to zero, matching the signed-stream encoding.
    always_comb begin
        d_inc = ACC_ZERO;
        if (x_p && !x_m) begin
            d_inc = ACC_PLUS;
        end else if (x_m && !x_p) begin
            d_inc = ACC_MINUS;
        end
    end

    assign acc_sum  = acc_q + d_inc;
    assign complete = en && (cnt_q == CNT_LAST);
    assign transfer = y_valid_q && y_ready;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        overrun_d = overrun_q;

        if (transfer) begin
            y_valid_d = 1'b0;
        end

        if (complete) begin
            acc_d     = ACC_ZERO;
            cnt_d     = '0;
            y_d       = acc_sum;
            y_valid_d = 1'b1;
            // Only an unconsumed result being replaced counts as an overrun.
            if (y_valid_q && !y_ready) begin
                overrun_d = 1'b1;
            end
        end else if (en) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST || clr) begin
            acc_q     <= ACC_ZERO;
            cnt_q     <= '0;
            y_q       <= ACC_ZERO;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_stoch_signed_decode.sv
// Directed bench for stoch_signed_decode with W=16: window sums, gating,
// backpressure/overrun, simultaneous accept+complete, clr and reset.
module tb_stoch_signed_decode;

    localparam int WL2 = 4;
    localparam int OW  = WL2 + 2;

    logic                 CLK;
    logic                 nRST;
    logic                 clr;
    logic                 en;
    logic                 x_p;
    logic                 x_m;
    logic signed [OW-1:0] y;
    logic                 y_valid;
    logic                 y_ready;
    logic                 overrun;

    int checks = 0;
    int errors = 0;
    int vc;

    stoch_signed_decode #(
        .WINDOW_LOG2(WL2),
        .OUT_WIDTH  (OW)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .clr    (clr),
        .en     (en),
        .x_p    (x_p),
        .x_m    (x_m),
        .y      (y),
        .y_valid(y_valid),
        .y_ready(y_ready),
        .overrun(overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive n cycles with the given sample inputs; count cycles showing y_valid=1.
    task automatic run(input int n, input logic e, input logic p, input logic m,
                       output int valid_cycles);
        valid_cycles = 0;
        en  = e;
        x_p = p;
        x_m = m;
        for (int i = 0; i < n; i++) begin
            tick();
            if (y_valid) valid_cycles++;
        end
    endtask

    task automatic check_out(input string tag, input int ey, input int ev, input int eo);
        check_eq({tag, "_y"}, int'(y), ey);
        check_eq({tag, "_valid"}, int'(y_valid), ev);
        check_eq({tag, "_overrun"}, int'(overrun), eo);
    endtask

    initial begin
        nRST = 1'b0; clr = 1'b0; en = 1'b1; x_p = 1'b1; x_m = 1'b0; y_ready = 1'b0;

        // Reset held with active stimulus
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", 0, 0, 0);
        end

        // Constant streams, y_ready=1
        nRST = 1'b1; y_ready = 1'b1;
        run(15, 1'b1, 1'b1, 1'b0, vc);
        check_eq("w1_early_valid", vc, 0);
        run(1, 1'b1, 1'b1, 1'b0, vc);
        check_out("w1_plus16", 16, 1, 0);
        run(1, 1'b1, 1'b0, 1'b1, vc);
        check_eq("w1_pulse_width", int'(y_valid), 0);
        run(14, 1'b1, 1'b0, 1'b1, vc);
        check_eq("w2_early_valid", vc, 0);
        run(1, 1'b1, 1'b0, 1'b1, vc);
        check_out("w2_minus16", -16, 1, 0);
        run(1, 1'b1, 1'b1, 1'b1, vc);
        check_eq("w2_pulse_width", int'(y_valid), 0);
        run(15, 1'b1, 1'b1, 1'b1, vc);
        check_out("w3_zero", 0, 1, 0);

        // Gated sampling: 10 up, 5 gated, 6 down
        run(10, 1'b1, 1'b1, 1'b0, vc);
        run(5, 1'b0, 1'b1, 1'b0, vc);
        check_eq("gated_no_result", int'(y_valid), 0);
        run(6, 1'b1, 1'b0, 1'b1, vc);
        check_out("gated_plus4", 4, 1, 0);

        // Backpressure and overrun
        run(1, 1'b0, 1'b0, 1'b0, vc);
        check_eq("drain_valid", int'(y_valid), 0);
        y_ready = 1'b0;
        run(16, 1'b1, 1'b1, 1'b0, vc);
        check_out("bp_first", 16, 1, 0);
        run(12, 1'b1, 1'b1, 1'b0, vc);
        run(4, 1'b1, 1'b0, 1'b1, vc);
        check_out("bp_overrun", 8, 1, 1);
        y_ready = 1'b1;
        run(1, 1'b0, 1'b0, 1'b0, vc);
        check_out("bp_accept", 8, 0, 1);

        // clr clears the sticky flag; then simultaneous accept and complete
        clr = 1'b1;
        run(1, 1'b1, 1'b1, 1'b0, vc);
        clr = 1'b0;
        check_out("clr_idle", 0, 0, 0);
        y_ready = 1'b0;
        run(16, 1'b1, 1'b1, 1'b0, vc);
        check_out("sim_first", 16, 1, 0);
        run(15, 1'b1, 1'b0, 1'b1, vc);
        check_out("sim_hold", 16, 1, 0);
        y_ready = 1'b1;
        run(1, 1'b1, 1'b0, 1'b1, vc);
        check_out("sim_complete", -16, 1, 0);
        y_ready = 1'b0;

        // Mid-window clr, with valid pending beforehand
        run(7, 1'b1, 1'b1, 1'b0, vc);
        clr = 1'b1;
        run(1, 1'b1, 1'b1, 1'b0, vc);
        clr = 1'b0;
        check_out("midclr", 0, 0, 0);
        run(9, 1'b1, 1'b0, 1'b1, vc);
        check_eq("midclr_no_early", vc, 0);
        run(7, 1'b1, 1'b0, 1'b1, vc);
        check_out("midclr_minus16", -16, 1, 0);

        // Mid-window reset discards the partial sum
        y_ready = 1'b1;
        run(5, 1'b1, 1'b0, 1'b1, vc);
        nRST = 1'b0;
        run(1, 1'b1, 1'b0, 1'b1, vc);
        check_out("midrst", 0, 0, 0);
        nRST = 1'b1;
        run(15, 1'b1, 1'b1, 1'b0, vc);
        check_eq("midrst_no_early", vc, 0);
        run(1, 1'b1, 1'b1, 1'b0, vc);
        check_out("midrst_plus16", 16, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
